relu_sched: RTL and testbench

- Sequencer for the ReLU activation stage of the coprocessor output path.
- Accepts a per-layer command (bypass flag, word count) and streams exactly that many words through the 2-cycle ReLU datapath.
- Tracks in-flight words and buffers results in a small output FIFO, so upstream/downstream valid/ready backpressure never drops a word.
- Marks the final word of each layer with dn_last.

---
 rtl/relu_sched.sv | 160 ++++++++++++++++
 tb/tb_relu_sched.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/relu_sched.sv
// relu_sched: sequences one layer of words through the external 2-cycle ReLU
// datapath. A 2-stage tag pipe tracks words inside the datapath, and a small
// output FIFO holds the results. Upstream credit is sized so the FIFO never
// overflows.
module relu_sched #(
    parameter int unsigned NUM_WIDTH  = 16,
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic                 cfg_bypass,
    input  logic [CNT_WIDTH-1:0] cfg_count,
    input  logic                 up_valid,
    output logic                 up_ready,
    input  logic [NUM_WIDTH-1:0] up_data,
    output logic                 relu_bypass,
    output logic [NUM_WIDTH-1:0] relu_up_data,
    input  logic [NUM_WIDTH-1:0] relu_dn_data,
    output logic                 dn_valid,
    input  logic                 dn_ready,
    output logic [NUM_WIDTH-1:0] dn_data,
    output logic                 dn_last,
    output logic                 busy
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned OccW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] remaining_q, remaining_d;
    logic                 bypass_q, bypass_d;

    logic                 tag0_vld_q, tag0_last_q;
    logic                 tag1_vld_q, tag1_last_q;

    logic [NUM_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    logic                 fifo_last_q [FIFO_DEPTH];
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [OccW-1:0]      occ_q;

    logic                 push, pop, up_fire, credit_avail;
    logic [OccW:0]        credits_used;

    // Words already committed to the FIFO plus words still inside the datapath.
    assign credits_used = {1'b0, occ_q} + {{OccW{1'b0}}, tag0_vld_q}
                        + {{OccW{1'b0}}, tag1_vld_q};
    assign credit_avail = credits_used < (OccW + 1)'(FIFO_DEPTH);

    assign push         = tag1_vld_q;
    assign dn_valid     = occ_q != '0;
    assign pop          = dn_valid && dn_ready;
    assign up_fire      = up_valid && up_ready;

    // Empty FIFO drives zeros so stale entries are never visible.
    assign dn_data      = dn_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign dn_last      = dn_valid && fifo_last_q[rd_ptr_q];

    assign relu_up_data = up_data;
    assign relu_bypass  = bypass_q;
    assign busy         = state_q != StIdle;

    // Next-state, layer bookkeeping and handshake readies.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        bypass_d    = bypass_q;
        cfg_ready   = 1'b0;
        up_ready    = 1'b0;
        unique case (state_q)
            StIdle: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    bypass_d    = cfg_bypass;
                    remaining_d = cfg_count;
                    if (cfg_count != '0) begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                up_ready = credit_avail;
                if (up_valid && credit_avail) begin
                    remaining_d = remaining_q - CNT_WIDTH'(1);
                    if (remaining_q == CNT_WIDTH'(1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (pop && dn_last) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM and layer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            bypass_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            bypass_q    <= bypass_d;
        end
    end

    // Tag pipe mirrors the datapath latency; stage 1 marks the FIFO write cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag0_vld_q  <= 1'b0;
            tag0_last_q <= 1'b0;
            tag1_vld_q  <= 1'b0;
            tag1_last_q <= 1'b0;
        end else begin
            tag0_vld_q  <= up_fire;
            tag0_last_q <= up_fire && (remaining_q == CNT_WIDTH'(1));
            tag1_vld_q  <= tag0_vld_q;
            tag1_last_q <= tag0_last_q;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   occ_q <= occ_q + OccW'(1);
                2'b01:   occ_q <= occ_q - OccW'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    // FIFO storage; contents are qualified by occupancy, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= relu_dn_data;
            fifo_last_q[wr_ptr_q] <= tag1_last_q;
        end
    end

endmodule

// File: tb/tb_relu_sched.sv
// Bench for relu_sched: table-driven layers, directed backpressure/null/reset
// sequences and random back-to-back layers checked against a word scoreboard.
module tb_relu_sched;

    localparam int NW = 16;
    localparam int CW = 16;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_valid = 1'b0, cfg_ready, cfg_bypass = 1'b0;
    logic [CW-1:0] cfg_count = '0;
    logic          up_valid = 1'b0, up_ready;
    logic [NW-1:0] up_data = '0;
    logic          relu_bypass;
    logic [NW-1:0] relu_up_data, relu_dn_data;
    logic          dn_valid, dn_ready = 1'b0, dn_last, busy;
    logic [NW-1:0] dn_data;

    always #5 clk = ~clk;

    relu_sched #(.NUM_WIDTH(NW), .CNT_WIDTH(CW), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_bypass(cfg_bypass),
        .cfg_count(cfg_count),
        .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data),
        .relu_bypass(relu_bypass), .relu_up_data(relu_up_data),
        .relu_dn_data(relu_dn_data),
        .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_data(dn_data),
        .dn_last(dn_last), .busy(busy)
    );

    // Stand-in for the 2-cycle ReLU datapath (no reset, like the real one).
    logic [NW-1:0] dp_s0, dp_s1;
    always_ff @(posedge clk) begin
        dp_s0 <= (relu_bypass || $signed(relu_up_data) >= 0) ? relu_up_data : '0;
        dp_s1 <= dp_s0;
    end
    assign relu_dn_data = dp_s1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {logic [NW-1:0] data; logic last;} word_t;
    typedef struct {logic byp; int cnt;} layer_t;
    typedef struct {
        logic            byp;
        int              cnt;
        logic [3:0][15:0] din;
        logic [3:0][15:0] dexp;
        logic [3:0]      lastm;
    } vec_t;

    word_t  exp_q[$];
    word_t  obs_q[$];
    layer_t lay_q[$];
    logic   cur_active = 1'b0, cur_byp = 1'b0;
    int     cur_cnt = 0, cur_idx = 0;
    int     acc_total = 0, pop_total = 0, last_total = 0;
    logic   last_pop_prev = 1'b0;
    logic   lat_arm = 1'b0;
    int     acc_c = -1, dv_c = -1;
    int     dn_mode = 0;
    logic   abort_sw = 1'b0, sw_done = 1'b0;
    vec_t   vecs[4];

    function automatic logic [NW-1:0] relu_ref(input logic [NW-1:0] x, input logic byp);
        int v;
        v = int'($signed(x));
        if (byp || v >= 0) return x;
        return '0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Observer and scoreboard, sampled mid-cycle.
    task automatic mon_cycle();
        word_t  w, o;
        layer_t l;
        if (last_pop_prev) begin
            chk("busy_after_last", 32'(busy), 0);
            chk("cfg_ready_after_last", 32'(cfg_ready), 1);
        end
        last_pop_prev = 1'b0;
        chk("cfg_ready_while_busy", 32'(cfg_ready && busy), 0);
        if (cfg_valid && cfg_ready && cfg_count != '0) begin
            l.byp = cfg_bypass;
            l.cnt = int'(cfg_count);
            lay_q.push_back(l);
        end
        if (up_valid && up_ready) begin
            if (!cur_active && lay_q.size() > 0) begin
                l = lay_q.pop_front();
                cur_byp = l.byp;
                cur_cnt = l.cnt;
                cur_idx = 0;
                cur_active = 1'b1;
            end
            chk("accept_in_layer", 32'(cur_active), 1);
            if (cur_active) begin
                w.data = relu_ref(up_data, cur_byp);
                w.last = (cur_idx == cur_cnt - 1);
                cur_idx++;
                if (w.last) cur_active = 1'b0;
                exp_q.push_back(w);
            end
            acc_total++;
            if (lat_arm && acc_c < 0) acc_c = cyc;
        end
        if (lat_arm && dn_valid && dv_c < 0) dv_c = cyc;
        if (dn_valid && dn_ready) begin
            o.data = dn_data;
            o.last = dn_last;
            obs_q.push_back(o);
            pop_total++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0h expected none", dn_data);
            end else begin
                w = exp_q.pop_front();
                chk("dn_data", 32'(dn_data), 32'(w.data));
                chk("dn_last", 32'(dn_last), 32'(w.last));
            end
            if (dn_last) begin
                last_total++;
                last_pop_prev = 1'b1;
            end
        end
        chk("credit_bound", 32'(acc_total - pop_total <= FD), 1);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) mon_cycle();
    end

    // Downstream ready: 0 = always, 1 = never, 2 = random.
    initial forever begin
        @(posedge clk);
        #1;
        case (dn_mode)
            0:       dn_ready = 1'b1;
            1:       dn_ready = 1'b0;
            default: dn_ready = ($urandom_range(99) < 60);
        endcase
    end

    task automatic do_cfg(input logic byp, input int cnt);
        int t = 0;
        cfg_valid = 1'b1;
        cfg_bypass = byp;
        cfg_count = CW'(cnt);
        @(negedge clk);
        while (!cfg_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (!cfg_ready) begin
            checks++;
            errors++;
            $display("FAIL cfg_timeout: got cfg_ready=0 expected 1");
        end
        tick();
        cfg_valid = 1'b0;
        cfg_bypass = 1'b0;
        cfg_count = CW'($urandom);
    endtask

    task automatic send_words(input logic [NW-1:0] w[$], input int vprob);
        for (int i = 0; i < w.size(); i++) begin
            int t = 0;
            bit done = 0;
            up_data = w[i];
            while (!done && !abort_sw) begin
                up_valid = ($urandom_range(99) < vprob);
                @(negedge clk);
                if (up_valid && up_ready) begin
                    done = 1;
                end else if (++t > 500) begin
                    checks++;
                    errors++;
                    $display("FAIL up_timeout: got no accept expected word %0d", i);
                    done = 1;
                end
                tick();
            end
            if (abort_sw) break;
        end
        up_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (busy && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy=1 expected 0");
        end
        tick();
    endtask

    task automatic run_row(input int r);
        logic [NW-1:0] w[$];
        dn_mode = 0;
        obs_q.delete();
        do_cfg(vecs[r].byp, vecs[r].cnt);
        for (int i = 0; i < vecs[r].cnt; i++) w.push_back(vecs[r].din[i]);
        send_words(w, 100);
        wait_idle();
        chk($sformatf("row%0d_count", r), 32'(obs_q.size()), 32'(vecs[r].cnt));
        for (int i = 0; i < vecs[r].cnt && i < obs_q.size(); i++) begin
            chk($sformatf("row%0d_data%0d", r, i), 32'(obs_q[i].data), 32'(vecs[r].dexp[i]));
            chk($sformatf("row%0d_last%0d", r, i), 32'(obs_q[i].last), 32'(vecs[r].lastm[i]));
        end
    endtask

    task automatic check_reset_outs(input string nm);
        chk({nm, "_cfg_ready"}, 32'(cfg_ready), 1);
        chk({nm, "_up_ready"}, 32'(up_ready), 0);
        chk({nm, "_dn_valid"}, 32'(dn_valid), 0);
        chk({nm, "_dn_data"}, 32'(dn_data), 0);
        chk({nm, "_dn_last"}, 32'(dn_last), 0);
        chk({nm, "_busy"}, 32'(busy), 0);
        chk({nm, "_relu_bypass"}, 32'(relu_bypass), 0);
    endtask

    task automatic flush_model();
        exp_q.delete();
        obs_q.delete();
        lay_q.delete();
        cur_active = 1'b0;
        last_pop_prev = 1'b0;
        acc_total = 0;
        pop_total = 0;
    endtask

    initial begin
        logic [NW-1:0] w[$];
        int a0, l0, t;

        vecs[0].byp = 1'b0; vecs[0].cnt = 3; vecs[0].lastm = 4'b0100;
        vecs[0].din  = {16'h0000, 16'h7FFF, 16'hFFFE, 16'h0005};
        vecs[0].dexp = {16'h0000, 16'h7FFF, 16'h0000, 16'h0005};
        vecs[1].byp = 1'b1; vecs[1].cnt = 2; vecs[1].lastm = 4'b0010;
        vecs[1].din  = {16'h0000, 16'h0000, 16'hFFFF, 16'h8000};
        vecs[1].dexp = {16'h0000, 16'h0000, 16'hFFFF, 16'h8000};
        vecs[2].byp = 1'b0; vecs[2].cnt = 4; vecs[2].lastm = 4'b1000;
        vecs[2].din  = {16'h1234, 16'h0000, 16'h0001, 16'h8001};
        vecs[2].dexp = {16'h1234, 16'h0000, 16'h0001, 16'h0000};
        vecs[3].byp = 1'b1; vecs[3].cnt = 1; vecs[3].lastm = 4'b0001;
        vecs[3].din  = {16'h0000, 16'h0000, 16'h0000, 16'hFFFE};
        vecs[3].dexp = {16'h0000, 16'h0000, 16'h0000, 16'hFFFE};

        #2;
        check_reset_outs("reset");
        tick();
        rst_n = 1'b1;
        tick();

        // Table layers; the first also measures accept-to-output latency.
        acc_c = -1;
        dv_c = -1;
        lat_arm = 1'b1;
        run_row(0);
        lat_arm = 1'b0;
        chk("latency", 32'(dv_c - acc_c), 3);
        for (int r = 1; r < 4; r++) run_row(r);

        // Backpressure: only FIFO_DEPTH words may be outstanding.
        dn_mode = 1;
        obs_q.delete();
        a0 = acc_total;
        w.delete();
        for (int i = 0; i < 8; i++) w.push_back(NW'(i * 16'h1111 + 16'h0100));
        do_cfg(1'b0, 8);
        sw_done = 1'b0;
        fork
            begin
                send_words(w, 100);
                sw_done = 1'b1;
            end
        join_none
        repeat (12) tick();
        @(negedge clk);
        chk("bp_accepted", 32'(acc_total - a0), 4);
        chk("bp_up_ready", 32'(up_ready), 0);
        tick();
        dn_mode = 0;
        wait_idle();
        t = 0;
        while (!sw_done && t < 50) begin
            tick();
            t++;
        end
        chk("bp_total_accepted", 32'(acc_total - a0), 8);
        chk("bp_total_out", 32'(obs_q.size()), 8);

        // Null layer: nothing happens, controller stays ready.
        do_cfg(1'b1, 0);
        up_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("null_idle", 32'({cfg_ready, busy, up_ready, dn_valid}), 32'(4'b1000));
        end
        tick();
        up_valid = 1'b0;
        run_row(3);

        // Random back-to-back layers with gaps on both sides.
        dn_mode = 2;
        l0 = last_total;
        for (int l = 0; l < 4; l++) begin
            w.delete();
            for (int i = 0; i < 16; i++) w.push_back(NW'($urandom));
            do_cfg(1'($urandom), 16);
            send_words(w, 70);
        end
        wait_idle();
        chk("rand_pending", 32'(exp_q.size()), 0);
        chk("rand_lasts", 32'(last_total - l0), 4);

        // Reset with words both in flight and buffered.
        dn_mode = 1;
        a0 = acc_total;
        w.delete();
        for (int i = 0; i < 10; i++) w.push_back(NW'(16'h0200 + i));
        do_cfg(1'b0, 10);
        abort_sw = 1'b0;
        sw_done = 1'b0;
        fork
            begin
                send_words(w, 100);
                sw_done = 1'b1;
            end
        join_none
        t = 0;
        @(negedge clk);
        while (acc_total - a0 < 4 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("pre_reset_accepted", 32'(acc_total - a0), 4);
        tick();
        chk("pre_reset_dn_valid", 32'(dn_valid), 1);
        abort_sw = 1'b1;
        rst_n = 1'b0;
        #1;
        check_reset_outs("midreset");
        flush_model();
        tick();
        t = 0;
        while (!sw_done && t < 20) begin
            tick();
            t++;
        end
        up_valid = 1'b0;
        abort_sw = 1'b0;
        tick();
        rst_n = 1'b1;
        dn_mode = 0;
        repeat (6) begin
            @(negedge clk);
            chk("post_reset_quiet", 32'({dn_valid, busy}), 0);
        end
        tick();
        run_row(0);
        run_row(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
